demux_1by16_deser: RTL and testbench

- Serial-to-parallel receiver: the inverse of the 16:1 select-and-serialize path.
- A 4-bit slot counter acts as the demux select. Each accepted serial bit is steered into the word slot addressed by the counter.
- After 16 bits, the assembled word is presented on a parallel output with a valid/ack handshake.
- Sits at the receive end of the serial link driven by the MUX_16by1 serializer stepping s = 0..15.

---
 rtl/demux_1by16_deser.sv | 114 +++++++++++
 tb/tb_demux_1by16_deser.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1by16_deser.sv
// ---------------------------------------------------------------------------
// demux_1by16_deser
//
// Serial-to-parallel receiver. This is the receive end of a 16:1
// select-and-serialize link. A slot counter acts as the demux select.
// Each accepted serial bit is written into the word slot that the counter
// addresses. Bit k of a frame lands in out_word[k], so the frame arrives
// LSB first.
//
// When the 16th bit is accepted, the assembled word is handed to a
// valid/ack output register. If a finished word replaces one that was
// never acknowledged, the sticky overrun flag is raised.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous, active-high reset
//   start     in   1      arm/restart frame collection (single-cycle pulse)
//   d_in      in   1      serial data bit
//   d_valid   in   1      d_in is valid this cycle
//   out_ack   in   1      consumer accepts out_word
//   sel       out  SEL_W  current slot index (demux select)
//   busy      out  1      high while collecting a frame
//   out_word  out  WIDTH  assembled parallel word
//   out_valid out  1      out_word holds an unconsumed word
//   overrun   out  1      a completed word replaced an unconsumed one
// ---------------------------------------------------------------------------
module demux_1by16_deser #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             d_in,
    input  logic             d_valid,
    input  logic             out_ack,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic [WIDTH-1:0] out_word,
    output logic             out_valid,
    output logic             overrun
);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [WIDTH-1:0]   r_slot;
    logic [WIDTH-1:0]   r_outWord;
    logic               r_outValid;
    logic               r_overrun;

    logic               w_accept;
    logic               w_complete;

    // A serial bit is only taken while collecting.
    // A start pulse in the same cycle wins, so that bit is dropped.
    // The frame completes on the bit that lands in the last slot.
    assign w_accept   = (r_state == COLLECT) && d_valid && !start;
    assign w_complete = w_accept && (r_sel == SEL_W'(WIDTH - 1));

    // Collection state machine and output handshake register.
    //
    // The final word is built from the stored slots plus the live d_in.
    // This presents the word on the cycle right after the last bit,
    // with no extra assembly cycle.
    //
    // A completion always loads a new word. It flags overrun only when
    // the previous word is still pending and is not being acked in the
    // same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_slot     <= '0;
            r_outWord  <= '0;
            r_outValid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (start) begin
                // Arm or restart: any partial frame is discarded.
                r_state <= COLLECT;
                r_sel   <= '0;
                r_slot  <= '0;
            end else if (w_accept) begin
                r_slot[r_sel] <= d_in;
                // The counter wraps naturally back to 0 after the last slot.
                r_sel         <= r_sel + SEL_W'(1);
                if (w_complete) begin
                    r_state <= IDLE;
                end
            end

            if (w_complete) begin
                r_outWord  <= {d_in, r_slot[WIDTH-2:0]};
                r_outValid <= 1'b1;
                r_overrun  <= r_outValid & ~out_ack;
            end else if (out_ack && r_outValid) begin
                r_outValid <= 1'b0;
                r_overrun  <= 1'b0;
            end
        end
    end

    assign sel       = r_sel;
    assign busy      = (r_state == COLLECT);
    assign out_word  = r_outWord;
    assign out_valid = r_outValid;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_demux_1by16_deser.sv
// ---------------------------------------------------------------------------
// tb_demux_1by16_deser
//
// Self-checking bench for demux_1by16_deser.
//
// Inputs are driven 1 ns after each rising edge. Outputs are sampled at
// that same point, so they never change near the active edge.
//
// The expected word is pushed into a scoreboard queue when the final bit
// of a frame is driven. It is popped and compared once the DUT presents
// the word.
// ---------------------------------------------------------------------------
module tb_demux_1by16_deser;

    logic        clk;
    logic        rst;
    logic        start;
    logic        d_in;
    logic        d_valid;
    logic        out_ack;
    logic [3:0]  sel;
    logic        busy;
    logic [15:0] out_word;
    logic        out_valid;
    logic        overrun;

    int checkCount;
    int failCount;

    logic [15:0] sbQueue[$];

    demux_1by16_deser #(
        .WIDTH (16),
        .SEL_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .d_in      (d_in),
        .d_valid   (d_valid),
        .out_ack   (out_ack),
        .sel       (sel),
        .busy      (busy),
        .out_word  (out_word),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then step to 1 ns after the next rising edge.
    task automatic applyStimulus(input logic iStart, input logic iValid,
                                 input logic iData, input logic iAck);
        start   = iStart;
        d_valid = iValid;
        d_in    = iData;
        out_ack = iAck;
        @(posedge clk);
        #1;
        start   = 1'b0;
        d_valid = 1'b0;
        d_in    = 1'b0;
        out_ack = 1'b0;
    endtask

    // Check every output against its reset value.
    task automatic checkResetState(input string tag);
        checkOutput({tag, "_sel"},      32'(sel),       32'h0);
        checkOutput({tag, "_busy"},     32'(busy),      32'h0);
        checkOutput({tag, "_outWord"},  32'(out_word),  32'h0);
        checkOutput({tag, "_outValid"}, 32'(out_valid), 32'h0);
        checkOutput({tag, "_overrun"},  32'(overrun),   32'h0);
    endtask

    // Send a full frame LSB first, starting with a start pulse.
    // gapAt/gapLen insert idle d_valid cycles before bit gapAt.
    // ackLast raises out_ack together with the final bit.
    task automatic sendFrame(input string tag, input logic [15:0] word,
                             input int gapAt, input int gapLen,
                             input logic ackLast);
        logic [15:0] expWord;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, "_busyStart"}, 32'(busy), 32'h1);
        for (int k = 0; k < 16; k++) begin
            if (k == gapAt) begin
                for (int g = 0; g < gapLen; g++) begin
                    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
                    checkOutput({tag, "_selGap"}, 32'(sel), 32'(k));
                end
            end
            checkOutput({tag, "_selCount"}, 32'(sel), 32'(k));
            checkOutput({tag, "_busyCollect"}, 32'(busy), 32'h1);
            if (k == 15) begin
                sbQueue.push_back(word);
            end
            applyStimulus(1'b0, 1'b1, word[k], (k == 15) ? ackLast : 1'b0);
        end
        if (sbQueue.size() == 0) begin
            checkOutput({tag, "_sbEmpty"}, 32'h1, 32'h0);
        end else begin
            expWord = sbQueue.pop_front();
            checkOutput({tag, "_outWord"}, 32'(out_word), 32'(expWord));
        end
        checkOutput({tag, "_outValid"}, 32'(out_valid), 32'h1);
        checkOutput({tag, "_busyDone"}, 32'(busy), 32'h0);
        checkOutput({tag, "_selWrap"}, 32'(sel), 32'h0);
    endtask

    // Acknowledge the pending word and confirm the handshake clears.
    task automatic ackWord(input string tag, input logic [15:0] heldWord);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput({tag, "_ackValid"}, 32'(out_valid), 32'h0);
        checkOutput({tag, "_ackOverrun"}, 32'(overrun), 32'h0);
        checkOutput({tag, "_ackHeld"}, 32'(out_word), 32'(heldWord));
    endtask

    // Main test sequence.
    initial begin
        checkCount = 0;
        failCount  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        d_in    = 1'b0;
        d_valid = 1'b0;
        out_ack = 1'b0;

        #2;
        checkResetState("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // d_valid toggling while idle must be ignored.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkResetState("idleIgnore");

        // Contiguous frame, then ack.
        sendFrame("contig", 16'hA5C3, -1, 0, 1'b0);
        checkOutput("contig_overrun", 32'(overrun), 32'h0);
        ackWord("contig", 16'hA5C3);

        // Gapped frame: d_valid low for 3 cycles between bits 7 and 8.
        sendFrame("gap", 16'h0F0F, 8, 3, 1'b0);
        ackWord("gap", 16'h0F0F);

        // Restart: 9 bits of a frame, then a new start and a full frame.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        end
        checkOutput("restart_selPartial", 32'(sel), 32'h9);
        checkOutput("restart_noWord", 32'(out_valid), 32'h0);
        sendFrame("restart", 16'h1234, -1, 0, 1'b0);
        checkOutput("restart_overrun", 32'(overrun), 32'h0);
        ackWord("restart", 16'h1234);

        // Start with d_valid in the same cycle: the bit must be dropped.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("startPrio_sel", 32'(sel), 32'h0);
        checkOutput("startPrio_busy", 32'(busy), 32'h1);

        // Overrun: two completions without an ack in between.
        sendFrame("ovrA", 16'hFFFF, -1, 0, 1'b0);
        checkOutput("ovrA_overrun", 32'(overrun), 32'h0);
        sendFrame("ovrB", 16'h8001, -1, 0, 1'b0);
        checkOutput("ovrB_overrun", 32'(overrun), 32'h1);
        // A stray cycle must not clear the sticky flag.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("ovrB_sticky", 32'(overrun), 32'h1);
        ackWord("ovrB", 16'h8001);
        // An ack with nothing pending must have no effect.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("idleAck_valid", 32'(out_valid), 32'h0);
        checkOutput("idleAck_word", 32'(out_word), 32'h8001);

        // Ack coinciding with completion: the new word loads, no overrun.
        sendFrame("pendA", 16'hAAAA, -1, 0, 1'b0);
        sendFrame("ackLast", 16'h5555, -1, 0, 1'b1);
        checkOutput("ackLast_overrun", 32'(overrun), 32'h0);

        // Async reset mid-frame, asserted between clock edges.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        end
        checkOutput("midRst_selBefore", 32'(sel), 32'h5);
        #2;
        rst = 1'b1;
        #1;
        checkResetState("midRst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkResetState("postRst");

        checkOutput("sbDrained", 32'(sbQueue.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

    // Safety net so the run always ends even if the sequence stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        failCount++;
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
